// File: rtl/cv32e40p_pkg.sv
// Shared multiplier types: operator codes, core MULH sequencing states, result-stage states.
// Latency: none; types only.
// Backpressure: none; types only.
package cv32e40p_pkg;

   typedef enum logic [2:0] {
      MUL_MAC32 = 3'b000,
      MUL_MSU32 = 3'b001,
      MUL_I     = 3'b010,
      MUL_IR    = 3'b011,
      MUL_DOT8  = 3'b100,
      MUL_DOT16 = 3'b101,
      MUL_H     = 3'b110
   } mul_opcode_e;

   // Multiplier core MULH sequencer as seen from outside the core
   typedef enum logic [2:0] {
      IDLE_MULT,
      STEP0,
      STEP1,
      STEP2,
      FINISH
   } mult_state_e;

   // Result stage: IDLE issues, WAIT_H follows a MULH, DRAIN lets a flushed MULH run out
   typedef enum logic [1:0] {
      IDLE,
      WAIT_H,
      DRAIN
   } mult_rs_state_e;

   // Complex result lands in one half-word, the other half keeps the destination operand
   function automatic logic [31:0] clpx_merge(input logic img, input logic [15:0] res,
                                              input logic [31:0] op_c);
      return img ? {res, op_c[15:0]} : {op_c[31:16], res};
   endfunction

endpackage

// File: rtl/cv32e40p_mult_result_stage_if.sv
// Bundle of request, multiplier-core and writeback signals around the result stage.
// Latency: none; wiring only.
// Backpressure: carried by req_ready_o, mult_ex_ready_o and res_ready_i.
interface cv32e40p_mult_result_stage_if;
   import cv32e40p_pkg::*;

   logic          req_valid_i;
   logic          req_ready_o;
   mul_opcode_e   operator_i;
   logic          is_clpx_i;
   logic          clpx_img_i;
   logic [31:0]   op_c_i;
   logic          flush_i;
   logic          mult_enable_o;
   logic          mult_ex_ready_o;
   logic          mult_ready_i;
   mult_state_e   mult_state_i;
   logic [31:0]   int_result_i;
   logic [31:0]   short_result_i;
   logic [31:0]   dot_char_result_i;
   logic [31:0]   dot_short_result_i;
   logic [15:0]   clpx_shift_result_i;
   logic          res_valid_o;
   logic          res_ready_i;
   logic [31:0]   res_data_o;

   // The result stage itself
   modport slave (
      input  req_valid_i, operator_i, is_clpx_i, clpx_img_i, op_c_i, flush_i,
             mult_ready_i, mult_state_i, int_result_i, short_result_i,
             dot_char_result_i, dot_short_result_i, clpx_shift_result_i, res_ready_i,
      output req_ready_o, mult_enable_o, mult_ex_ready_o, res_valid_o, res_data_o
   );

   // Everything around it: issue logic, multiplier core, writeback
   modport master (
      output req_valid_i, operator_i, is_clpx_i, clpx_img_i, op_c_i, flush_i,
             mult_ready_i, mult_state_i, int_result_i, short_result_i,
             dot_char_result_i, dot_short_result_i, clpx_shift_result_i, res_ready_i,
      input  req_ready_o, mult_enable_o, mult_ex_ready_o, res_valid_o, res_data_o
   );

endinterface

// File: rtl/cv32e40p_mult_result_mux.sv
// Picks the core result belonging to the operator and packs complex half-word results.
// Latency: purely combinational.
// Backpressure: none.
module cv32e40p_mult_result_mux
   import cv32e40p_pkg::*;
(
   input  mul_opcode_e operator_i,
   input  logic        is_clpx_i,
   input  logic        clpx_img_i,
   input  logic [31:0] op_c_i,
   input  logic [31:0] int_result_i,
   input  logic [31:0] short_result_i,
   input  logic [31:0] dot_char_result_i,
   input  logic [31:0] dot_short_result_i,
   input  logic [15:0] clpx_shift_result_i,
   output logic [31:0] result_o
);

   // Operator-driven result select; short result covers MUL_I, MUL_IR and MUL_H
   always_comb begin
      result_o = short_result_i;
      case (operator_i)
         MUL_MAC32, MUL_MSU32: result_o = int_result_i;
         MUL_DOT8:             result_o = dot_char_result_i;
         MUL_DOT16:            result_o = is_clpx_i
                                        ? clpx_merge(clpx_img_i, clpx_shift_result_i, op_c_i)
                                        : dot_short_result_i;
         default:              result_o = short_result_i;
      endcase
   end

endmodule

// File: rtl/cv32e40p_mult_result_stage.sv
// Issues multiply requests to the core, sequences MULH to FINISH, registers the result for writeback.
// Latency: single-cycle ops valid one cycle after accept; MULH accepts in the core FINISH cycle, valid next.
// Backpressure: an unconsumed result blocks accepts and withholds ex_ready, parking the core in FINISH.
module cv32e40p_mult_result_stage
   import cv32e40p_pkg::*;
(
   input logic                          clk,
   input logic                          rst_n,
   cv32e40p_mult_result_stage_if.slave  bus
);

   mult_rs_state_e state_q, state_d;
   logic           res_valid_q;
   logic [31:0]    res_data_q;
   logic [31:0]    sel_result;
   logic           slot_free;
   logic           req_ready;
   logic           mult_enable;
   logic           mult_ex_ready;
   logic           capture;

   // Output register can take a new result if empty or being drained this cycle
   assign slot_free = ~res_valid_q | bus.res_ready_i;
   assign capture   = bus.req_valid_i & req_ready;

   cv32e40p_mult_result_mux u_mux (
      .operator_i          (bus.operator_i),
      .is_clpx_i           (bus.is_clpx_i),
      .clpx_img_i          (bus.clpx_img_i),
      .op_c_i              (bus.op_c_i),
      .int_result_i        (bus.int_result_i),
      .short_result_i      (bus.short_result_i),
      .dot_char_result_i   (bus.dot_char_result_i),
      .dot_short_result_i  (bus.dot_short_result_i),
      .clpx_shift_result_i (bus.clpx_shift_result_i),
      .result_o            (sel_result)
   );

   // Next state and handshake toward upstream and the core; flush always blocks accept
   always_comb begin
      state_d       = state_q;
      mult_enable   = 1'b0;
      mult_ex_ready = 1'b1;
      req_ready     = 1'b0;
      case (state_q)
         IDLE: begin
            mult_enable   = bus.req_valid_i & ~bus.flush_i;
            mult_ex_ready = slot_free;
            if (bus.req_valid_i && !bus.flush_i) begin
               if (bus.operator_i == MUL_H) state_d = WAIT_H;
               else                         req_ready = slot_free;
            end
         end
         WAIT_H: begin
            mult_enable   = bus.req_valid_i & ~bus.flush_i;
            mult_ex_ready = slot_free;
            req_ready     = bus.mult_ready_i & (bus.mult_state_i == FINISH) & slot_free
                            & ~bus.flush_i;
            if (bus.flush_i) begin
               // A core already mid-sequence must be allowed to run back to idle
               state_d = (bus.mult_state_i != IDLE_MULT) ? DRAIN : IDLE;
            end else if (bus.req_valid_i && req_ready) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (bus.mult_state_i == IDLE_MULT) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // One-entry result register with flow-through on simultaneous consume and capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else if (bus.flush_i) begin
         res_valid_q <= 1'b0;
      end else if (capture) begin
         res_valid_q <= 1'b1;
         res_data_q  <= sel_result;
      end else if (bus.res_ready_i) begin
         res_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready_o     = req_ready;
   assign bus.mult_enable_o   = mult_enable;
   assign bus.mult_ex_ready_o = mult_ex_ready;
   assign bus.res_valid_o     = res_valid_q;
   assign bus.res_data_o      = res_data_q;

endmodule

// File: tb/tb_cv32e40p_mult_result_stage.sv
// Bench for the multiply result stage with a behavioural multiplier core and transaction-level model.
// Latency: checks every cycle at the falling edge.
// Backpressure: randomised writeback ready and flushes.
module tb_cv32e40p_mult_result_stage;
   import cv32e40p_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cv32e40p_mult_result_stage_if bus ();
   mult_state_e cstate;

   assign bus.mult_state_i = cstate;
   assign bus.mult_ready_i = (cstate == IDLE_MULT) || (cstate == FINISH);

   cv32e40p_mult_result_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: result register contents, MULH outstanding, flushed MULH still running in the core
   logic        m_valid   = 1'b0;
   logic [31:0] m_data    = '0;
   logic        m_pending = 1'b0;
   logic        m_orphan  = 1'b0;
   logic        m_acc     = 1'b0;

   mul_opcode_e ops [7] = '{MUL_MAC32, MUL_MSU32, MUL_I, MUL_IR, MUL_DOT8, MUL_DOT16, MUL_H};

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Value writeback must see for a given operator and core outputs
   function automatic logic [31:0] ref_result(input mul_opcode_e op, input logic clpx,
                                              input logic img, input logic [31:0] opc,
                                              input logic [31:0] ir, input logic [31:0] sr,
                                              input logic [31:0] dc, input logic [31:0] ds,
                                              input logic [15:0] cs);
      if (op == MUL_MAC32 || op == MUL_MSU32) return ir;
      if (op == MUL_DOT8) return dc;
      if (op == MUL_DOT16) begin
         if (!clpx) return ds;
         if (img)   return {cs, opc[15:0]};
         return {opc[31:16], cs};
      end
      return sr;
   endfunction

   // Behavioural multiplier core: MULH walks STEP0..STEP2 into FINISH, leaves on ex_ready
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cstate <= IDLE_MULT;
      else begin
         case (cstate)
            IDLE_MULT: if (bus.mult_enable_o && bus.operator_i == MUL_H) cstate <= STEP0;
            STEP0:     cstate <= STEP1;
            STEP1:     cstate <= STEP2;
            STEP2:     cstate <= FINISH;
            FINISH:    if (bus.mult_ex_ready_o) cstate <= IDLE_MULT;
            default:   cstate <= IDLE_MULT;
         endcase
      end
   end

   // Per-cycle comparison against the model, then advance the model
   always @(negedge clk) begin
      logic sf, e_en, e_exr, e_rr;
      if (!rst_n) begin
         chk1("rst_res_valid", bus.res_valid_o, 1'b0);
         chk32("rst_res_data", bus.res_data_o, 32'h0);
         chk1("rst_req_ready", bus.req_ready_o, 1'b0);
         chk1("rst_enable", bus.mult_enable_o, 1'b0);
         chk1("rst_ex_ready", bus.mult_ex_ready_o, 1'b1);
         m_valid = 1'b0; m_data = '0; m_pending = 1'b0; m_orphan = 1'b0; m_acc = 1'b0;
      end else begin
         sf = !m_valid || bus.res_ready_i;
         if (m_orphan) begin
            e_en = 1'b0; e_exr = 1'b1; e_rr = 1'b0;
         end else begin
            e_en  = bus.req_valid_i && !bus.flush_i;
            e_exr = sf;
            if (m_pending)
               e_rr = !bus.flush_i && bus.mult_ready_i && cstate == FINISH && sf;
            else
               e_rr = bus.req_valid_i && !bus.flush_i && bus.operator_i != MUL_H && sf;
         end
         chk1("model_req_ready", bus.req_ready_o, e_rr);
         chk1("model_enable", bus.mult_enable_o, e_en);
         chk1("model_ex_ready", bus.mult_ex_ready_o, e_exr);
         chk1("model_res_valid", bus.res_valid_o, m_valid);
         chk32("model_res_data", bus.res_data_o, m_data);

         m_acc = bus.req_valid_i && e_rr;
         if (bus.flush_i) m_valid = 1'b0;
         else if (m_acc) begin
            m_valid = 1'b1;
            m_data  = ref_result(bus.operator_i, bus.is_clpx_i, bus.clpx_img_i, bus.op_c_i,
                                 bus.int_result_i, bus.short_result_i, bus.dot_char_result_i,
                                 bus.dot_short_result_i, bus.clpx_shift_result_i);
         end else if (bus.res_ready_i) m_valid = 1'b0;

         if (m_orphan) begin
            if (cstate == IDLE_MULT) m_orphan = 1'b0;
         end else if (m_pending) begin
            if (bus.flush_i) begin
               m_pending = 1'b0;
               m_orphan  = (cstate != IDLE_MULT);
            end else if (m_acc) m_pending = 1'b0;
         end else if (bus.req_valid_i && !bus.flush_i && bus.operator_i == MUL_H) begin
            m_pending = 1'b1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_results();
      bus.int_result_i        = $urandom;
      bus.short_result_i      = $urandom;
      bus.dot_char_result_i   = $urandom;
      bus.dot_short_result_i  = $urandom;
      bus.clpx_shift_result_i = 16'($urandom);
   endtask

   task automatic issue(input mul_opcode_e op);
      bus.req_valid_i = 1'b1;
      bus.operator_i  = op;
      bus.is_clpx_i   = 1'b0;
      bus.clpx_img_i  = 1'b0;
   endtask

   initial begin
      int lat;
      int drain;
      bus.req_valid_i = 1'b0;
      bus.operator_i  = MUL_MAC32;
      bus.is_clpx_i   = 1'b0;
      bus.clpx_img_i  = 1'b0;
      bus.op_c_i      = '0;
      bus.flush_i     = 1'b0;
      bus.res_ready_i = 1'b0;
      rand_results();

      // Reset
      repeat (3) cyc();
      rst_n = 1'b1;
      bus.res_ready_i = 1'b1;

      // MAC32 single-cycle path
      cyc();
      issue(MUL_MAC32);
      bus.int_result_i = 32'h12345678;
      @(negedge clk);
      chk1("mac_req_ready", bus.req_ready_o, 1'b1);
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk1("mac_res_valid", bus.res_valid_o, 1'b1);
      chk32("mac_res_data", bus.res_data_o, 32'h12345678);

      // MULH: accept only in FINISH, four cycles after the first enable
      cyc();
      issue(MUL_H);
      bus.short_result_i = 32'hCAFEF00D;
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) chk1("mulh_enable", bus.mult_enable_o, 1'b1);
         if (bus.req_ready_o) begin
            lat = k;
            break;
         end
         cyc();
      end
      chk32("mulh_latency", 32'(lat), 32'd4);
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk1("mulh_res_valid", bus.res_valid_o, 1'b1);
      chk32("mulh_res_data", bus.res_data_o, 32'hCAFEF00D);

      // Complex DOT16, imaginary then real, back to back
      cyc();
      issue(MUL_DOT16);
      bus.is_clpx_i = 1'b1;
      bus.clpx_img_i = 1'b1;
      bus.op_c_i = 32'hAAAA5555;
      bus.clpx_shift_result_i = 16'h1234;
      cyc();
      bus.clpx_img_i = 1'b0;
      @(negedge clk);
      chk32("clpx_img_data", bus.res_data_o, 32'h12345555);
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk32("clpx_real_data", bus.res_data_o, 32'hAAAA1234);

      // Backpressure: held result blocks the next MUL_I until writeback consumes
      cyc();
      issue(MUL_I);
      bus.short_result_i = 32'h11111111;
      bus.res_ready_i = 1'b0;
      cyc();
      bus.short_result_i = 32'h22222222;
      @(negedge clk);
      chk1("bp_req_ready", bus.req_ready_o, 1'b0);
      chk32("bp_data_held", bus.res_data_o, 32'h11111111);
      cyc();
      @(negedge clk);
      chk1("bp_enable", bus.mult_enable_o, 1'b1);
      chk1("bp_ex_ready", bus.mult_ex_ready_o, 1'b0);
      chk32("bp_data_still", bus.res_data_o, 32'h11111111);
      cyc();
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      chk1("bp_release_ready", bus.req_ready_o, 1'b1);
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk32("bp_new_data", bus.res_data_o, 32'h22222222);
      chk1("bp_new_valid", bus.res_valid_o, 1'b1);

      // Flush while the core is in STEP1
      cyc();
      issue(MUL_H);
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (cstate == STEP1) break;
      end
      bus.flush_i = 1'b1;
      @(negedge clk);
      chk1("flush_enable", bus.mult_enable_o, 1'b0);
      chk1("flush_req_ready", bus.req_ready_o, 1'b0);
      cyc();
      bus.flush_i = 1'b0;
      bus.req_valid_i = 1'b0;
      drain = 99;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk1("drain_res_valid", bus.res_valid_o, 1'b0);
         chk1("drain_ex_ready", bus.mult_ex_ready_o, 1'b1);
         if (cstate == IDLE_MULT) begin
            drain = k;
            break;
         end
         cyc();
      end
      chk32("drain_cycles", 32'(drain), 32'd2);
      cyc();
      issue(MUL_I);
      bus.short_result_i = 32'h5A5A5A5A;
      @(negedge clk);
      chk1("post_flush_ready", bus.req_ready_o, 1'b1);
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk32("post_flush_data", bus.res_data_o, 32'h5A5A5A5A);

      // Asynchronous reset during STEP2
      cyc();
      issue(MUL_H);
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (cstate == STEP2) break;
      end
      rst_n = 1'b0;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk32("rst_mid_data", bus.res_data_o, 32'h0);
      chk1("rst_mid_valid", bus.res_valid_o, 1'b0);
      chk1("rst_mid_core_idle", cstate == IDLE_MULT, 1'b1);
      cyc();
      rst_n = 1'b1;
      cyc();
      issue(MUL_I);
      bus.short_result_i = 32'h0BADBEEF;
      cyc();
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk32("rst_resume_data", bus.res_data_o, 32'h0BADBEEF);

      // Randomised traffic; requests held until accepted, dropped on flush
      for (int i = 0; i < 3000; i++) begin
         cyc();
         bus.res_ready_i = ($urandom_range(0, 3) != 0);
         rand_results();
         if (!bus.req_valid_i || m_acc || bus.flush_i) begin
            if ($urandom_range(0, 9) < 7) begin
               bus.req_valid_i = 1'b1;
               bus.operator_i  = ops[$urandom_range(0, 6)];
               bus.is_clpx_i   = 1'($urandom);
               bus.clpx_img_i  = 1'($urandom);
               bus.op_c_i      = $urandom;
            end else begin
               bus.req_valid_i = 1'b0;
            end
         end
         bus.flush_i = ($urandom_range(0, 24) == 0);
      end
      cyc();
      bus.req_valid_i = 1'b0;
      bus.flush_i = 1'b0;
      repeat (8) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
